prod_accum: RTL and testbench
=============================

// Module: prod_accum
// PURPOSE
//   Sequential accumulator directly downstream of the 3x3 array multiplier.
//   Consumes one 6-bit product per valid/ready handshake, sums N_TERMS products
//   into a frame total, then presents the total on an output valid/ready port.
//   Provides a registered dot-product/MAC stage behind the combinational multiplier.
// PARAMETERS
//   PW       6  product input width (matches multiplier P[5:0])
//   N_TERMS  4  products summed per frame (>=1; term counter sized $clog2(N_TERMS+1))
//   ACC_W    8  accumulator/output width (>=PW)
// PORTS
//   clk        in   1      clock, all logic on rising edge
//   rst_n      in   1      synchronous active-low reset
//   p_in       in   PW     product from multiplier (unsigned)
//   p_valid    in   1      p_in valid
//   p_ready    out  1      block can accept p_in this cycle
//   clr        in   1      synchronous frame abort
//   acc_out    out  ACC_W  frame sum, stable while acc_valid=1
//   acc_valid  out  1      acc_out valid
//   acc_ready  in   1      downstream accepts acc_out
//   ovf        out  1      sticky: frame sum exceeded 2^ACC_W-1
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): state=ACCUM, acc_out=0, cnt=0, acc_valid=0, ovf=0.
//     p_ready=1 from the first cycle after reset release.
//   - States: ACCUM (p_ready=1, acc_valid=0); DONE (p_ready=0, acc_valid=1).
//   - ACCUM: on p_valid&p_ready: acc_out<=acc_out+p_in, cnt<=cnt+1.
//     Addition done at ACC_W+1 bits; carry-out sets ovf (sticky within the frame).
//     When the accepted term is term N_TERMS: next state DONE, cnt<=0.
//     The sum is visible on acc_out with acc_valid=1 one cycle after the last handshake.
//   - p_valid=0 in ACCUM: hold acc_out/cnt; no timeout.
//   - DONE: hold acc_out and ovf while acc_ready=0.
//     On acc_ready=1: next cycle state=ACCUM, acc_out=0, ovf=0, p_ready=1.
//     No p_in is accepted in the handoff cycle.
//   - clr=1 (any state): next cycle state=ACCUM, acc_out=0, cnt=0, ovf=0, acc_valid=0.
//     clr overrides handshakes in the same cycle. rst_n overrides clr.
//   - N_TERMS=1: every accepted product goes straight to DONE.
//   - p_in is sampled only on handshake; p_in is don't-care otherwise.
//   - No combinational path from any input to p_ready/acc_valid (both decode registered state).
// CONFIGURATION
//   PROD_ACCUM_SAT_EN defined:
//     On carry-out the accumulator clamps to 2^ACC_W-1 and stays clamped for the rest
//     of the frame. ovf is still set.
//   Not defined:
//     Modulo-2^ACC_W wrap-around. ovf is still set.
// TESTING
//   1 Reset: rst_n=0 for 2 clk -> acc_out=0, acc_valid=0, ovf=0; p_ready=1 after release.
//   2 Frame: 4x p_in=49 (7*7), back-to-back valid, acc_ready=1 -> acc_out=196,
//     acc_valid for 1 cycle, ovf=0.
//   3 Backpressure: frame p_in=1,2,3,4 with gapped p_valid; acc_ready=0 for 5 cycles
//     -> acc_out=10 held, p_ready=0 throughout, then cleared after acc_ready=1.
//   4 Overflow: N_TERMS=8, 8x p_in=49
//     -> without SAT_EN: acc_out=136, ovf=1;
//     -> with PROD_ACCUM_SAT_EN: acc_out=255, ovf=1.
//   5 Abort: clr=1 after 2 terms (p_in=5,6) with p_valid=1 in the same cycle
//     -> product ignored; next frame 4x p_in=1 gives acc_out=4.
//   6 Random: exhaustive A,B through the multiplier into the block
//     -> every frame matches a reference sum mod 256 and the reference ovf.

Source files
------------

// File: rtl/prod_accum.sv
// prod_accum: sums N_TERMS handshaked products per frame; PROD_ACCUM_SAT_EN selects saturating instead of wrapping overflow
module prod_accum #(
  parameter int PW      = 6,
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PW-1:0]    p_in,
  input  logic             p_valid,
  output logic             p_ready,
  input  logic             clr,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             ovf
);
  localparam int CW = $clog2(N_TERMS + 1);
  typedef enum logic {ACCUM, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [ACC_W:0] sum;
  logic [ACC_W-1:0] acc_nx;
  logic take, last;
  assign p_ready   = state == ACCUM;
  assign acc_valid = state == DONE;
  assign take      = p_valid && p_ready;
  assign last      = cnt == CW'(N_TERMS - 1);
  assign sum       = {1'b0, acc_out} + (ACC_W + 1)'(p_in);
`ifdef PROD_ACCUM_SAT_EN
  assign acc_nx = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
  assign acc_nx = sum[ACC_W-1:0];
`endif
  // state register
  always_ff @(posedge clk) state <= !rst_n ? ACCUM : state_nx;
  // next state: clr aborts, last accepted term finishes the frame, downstream accept reopens input
  always_comb begin
    state_nx = clr ? ACCUM : (take && last) ? DONE : (acc_valid && acc_ready) ? ACCUM : state;
  end
  // accumulator, term counter and sticky overflow; cleared on abort or on result handoff
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      acc_out <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
    end else if (take) begin
      acc_out <= acc_nx;
      cnt     <= last ? '0 : cnt + 1'b1;
      ovf     <= ovf | sum[ACC_W];
    end else if (acc_valid && acc_ready) begin
      acc_out <= '0;
      ovf     <= 1'b0;
    end
  end
endmodule

// File: tb/tb_prod_accum.sv
// tb_prod_accum: vector table, hand sequences and scoreboarded exhaustive frames for prod_accum
module tb_prod_accum;
  logic clk = 0, rst_n = 0, clr = 0, ar = 0, pv4 = 0, pv8 = 0;
  logic [5:0] p_in = '0;
  logic pr4, av4, ovf4, pr8, av8, ovf8;
  logic [7:0] acc4, acc8;
  int checks = 0, fails = 0;
  bit sb_en = 0, sel8 = 0;
  logic [8:0] q[$];
`ifdef PROD_ACCUM_SAT_EN
  localparam int SAT = 1, E6 = 255, E8 = 255;
`else
  localparam int SAT = 0, E6 = 38, E8 = 136;
`endif
  always #5 clk = ~clk;
  prod_accum #(.PW(6), .N_TERMS(4), .ACC_W(8)) u4 (
    .clk(clk), .rst_n(rst_n), .p_in(p_in), .p_valid(pv4), .p_ready(pr4), .clr(clr),
    .acc_out(acc4), .acc_valid(av4), .acc_ready(ar), .ovf(ovf4));
  prod_accum #(.PW(6), .N_TERMS(8), .ACC_W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .p_in(p_in), .p_valid(pv8), .p_ready(pr8), .clr(clr),
    .acc_out(acc8), .acc_valid(av8), .acc_ready(ar), .ovf(ovf8));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic [5:0] p, input logic v4, input logic v8, input logic c, input logic r);
    p_in = p; pv4 = v4; pv8 = v8; clr = c; ar = r;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb_en && ar && (sel8 ? av8 : av4)) begin
      if (q.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        logic [8:0] e;
        e = q.pop_front();
        chk(sel8 ? "sb_acc8" : "sb_acc4", sel8 ? acc8 : acc4, e[7:0]);
        chk(sel8 ? "sb_ovf8" : "sb_ovf4", sel8 ? ovf8 : ovf4, e[8]);
      end
    end
  end

  task automatic feed(input bit w8);
    int nt, acc_m, cnt_m, s;
    bit ov_m;
    nt = w8 ? 8 : 4; acc_m = 0; cnt_m = 0; ov_m = 0;
    sel8 = w8; sb_en = 1;
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        int wn = 0;
        while ((w8 ? pr8 : pr4) !== 1'b1 || $urandom_range(0, 3) == 0) begin
          if (wn++ > 60) begin chk("rnd_ready_timeout", 0, 1); break; end
          step(6'($urandom), 0, 0, 0, 1'($urandom));
        end
        s = acc_m + a * b;
        if (s > 255) begin ov_m = 1; acc_m = SAT ? 255 : s % 256; end
        else acc_m = s;
        if (++cnt_m == nt) begin
          q.push_back({ov_m, 8'(acc_m)});
          acc_m = 0; cnt_m = 0; ov_m = 0;
        end
        step(6'(a * b), !w8, w8, 0, 1'($urandom));
      end
    end
    for (int i = 0; i < 40 && q.size() != 0; i++) step(0, 0, 0, 0, 1);
    chk(w8 ? "drain_q8" : "drain_q4", q.size(), 0);
    sb_en = 0;
  endtask

  typedef struct {
    logic [5:0] p; logic v, c, r;
    logic [7:0] acc; logic av, pr, ov;
  } vec_t;
  vec_t tbl[13];

  initial begin
    tbl[0]  = '{6'd49, 1, 0, 1, 8'd49,  0, 1, 0};
    tbl[1]  = '{6'd49, 1, 0, 1, 8'd98,  0, 1, 0};
    tbl[2]  = '{6'd49, 1, 0, 1, 8'd147, 0, 1, 0};
    tbl[3]  = '{6'd49, 1, 0, 1, 8'd196, 1, 0, 0};
    tbl[4]  = '{6'd0,  0, 0, 1, 8'd0,   0, 1, 0};
    tbl[5]  = '{6'd5,  1, 0, 0, 8'd5,   0, 1, 0};
    tbl[6]  = '{6'd6,  1, 0, 0, 8'd11,  0, 1, 0};
    tbl[7]  = '{6'd7,  1, 1, 0, 8'd0,   0, 1, 0};
    tbl[8]  = '{6'd1,  1, 0, 0, 8'd1,   0, 1, 0};
    tbl[9]  = '{6'd1,  1, 0, 0, 8'd2,   0, 1, 0};
    tbl[10] = '{6'd1,  1, 0, 0, 8'd3,   0, 1, 0};
    tbl[11] = '{6'd1,  1, 0, 0, 8'd4,   1, 0, 0};
    tbl[12] = '{6'd0,  0, 0, 1, 8'd0,   0, 1, 0};
    rst_n = 0;
    step(49, 1, 1, 1, 1);
    step(49, 1, 1, 1, 1);
    chk("rst_acc", acc4, 0);
    chk("rst_valid", av4, 0);
    chk("rst_ovf", ovf4, 0);
    chk("rst_acc8", acc8, 0);
    rst_n = 1;
    step(0, 0, 0, 0, 0);
    chk("rst_p_ready", pr4, 1);
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].p, tbl[i].v, 0, tbl[i].c, tbl[i].r);
      chk($sformatf("vec%0d_acc", i), acc4, tbl[i].acc);
      chk($sformatf("vec%0d_valid", i), av4, tbl[i].av);
      chk($sformatf("vec%0d_ready", i), pr4, tbl[i].pr);
      chk($sformatf("vec%0d_ovf", i), ovf4, tbl[i].ov);
    end
    step(1, 1, 0, 0, 0);
    step(63, 0, 0, 0, 0);
    step(2, 1, 0, 0, 0);
    step(63, 0, 0, 0, 0);
    step(3, 1, 0, 0, 0);
    step(4, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_acc", acc4, 10);
      chk("bp_valid", av4, 1);
      chk("bp_p_ready", pr4, 0);
      step(9, 1, 0, 0, 0);
    end
    step(9, 1, 0, 0, 1);
    chk("bp_clear_acc", acc4, 0);
    chk("bp_clear_valid", av4, 0);
    chk("bp_clear_ready", pr4, 1);
    for (int i = 0; i < 6; i++) step(49, 0, 1, 0, 0);
    chk("ovf6_acc", acc8, E6);
    chk("ovf6_sticky", ovf8, 1);
    step(49, 0, 1, 0, 0);
    step(49, 0, 1, 0, 0);
    chk("ovf8_acc", acc8, E8);
    chk("ovf8_flag", ovf8, 1);
    chk("ovf8_valid", av8, 1);
    step(0, 0, 0, 0, 1);
    chk("ovf8_clear_acc", acc8, 0);
    chk("ovf8_clear_flag", ovf8, 0);
    step(49, 0, 1, 0, 0);
    step(49, 0, 1, 1, 0);
    chk("clr_acc8", acc8, 0);
    feed(0);
    feed(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
